// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit in front of a word-organised data memory.
// One request at a time: IDLE -> ACCESS -> RESP -> IDLE (3 cycles per request).
// Optional build macro MISALIGNED_SPLIT_EN: misaligned halfword/word accesses are
// performed instead of faulting; word-crossing ones take an extra ACCESS2 cycle
// on the following word.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic [3:0]        mem_byte_enable,
    output logic              mem_write_enable,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
`ifdef MISALIGNED_SPLIT_EN
        , ACCESS2 = 2'd3
`endif
    } state_t;

    state_t            state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              fault_q;

    logic              req_illegal;
    logic              req_fault;
    logic [1:0]        off;
    logic [3:0]        size_mask;
    logic [3:0]        lo_mask;
    logic [31:0]       repl;
    logic [31:0]       rot_data;
    logic [31:0]       lane_data;

    // Sign/zero extension of the right-aligned load data by funct3
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Classify the incoming request: funct3 legality per direction
    always_comb begin
        if (req_we)
            req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end

`ifdef MISALIGNED_SPLIT_EN
    assign req_fault = req_illegal;
`else
    logic req_misaligned;
    // Halfwords must be 2-byte aligned and words 4-byte aligned
    always_comb begin
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end
    assign req_fault = req_illegal | req_misaligned;
`endif

    assign off       = addr_q[1:0];
    assign req_ready = (state == IDLE);

    // Access-size mask and store data replicated to fill the word
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                size_mask = 4'b0001;
                repl      = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                size_mask = 4'b0011;
                repl      = {2{wdata_q[15:0]}};
            end
            default: begin
                size_mask = 4'b1111;
                repl      = wdata_q;
            end
        endcase
    end

    // Rotating by the byte offset puts each store byte on its lane; for aligned
    // accesses this equals the plain replication, and for a crossing store the
    // same rotated word serves both the low and the high part.
    assign rot_data  = (repl << {off, 3'b000}) | (repl >> (6'd32 - {1'b0, off, 3'b000}));
    assign lane_data = mem_read_data >> {off, 3'b000};

`ifdef MISALIGNED_SPLIT_EN
    logic [7:0]  mask8;
    logic [3:0]  hi_mask;
    logic        crossing;
    logic [31:0] lo_q;
    logic [31:0] merged;
    logic [4:0]  hi_shift;

    assign mask8    = {4'b0000, size_mask} << off;
    assign lo_mask  = mask8[3:0];
    assign hi_mask  = mask8[7:4];
    assign crossing = |hi_mask;
    // High bytes from the next word land just above the (4-off) bytes held from word A
    assign hi_shift = {(~off) + 2'd1, 3'b000};
    assign merged   = lo_q | (mem_read_data << hi_shift);
`else
    assign lo_mask  = size_mask << off;
`endif

    // Memory-side drive: only in the access state(s) and only for non-faulting requests
    always_comb begin
        mem_address      = {addr_q[ADDR_W-1:2], 2'b00};
        mem_byte_enable  = 4'b0000;
        mem_write_data   = 32'h0;
        mem_write_enable = 1'b0;
        if (state == ACCESS && !fault_q) begin
            mem_byte_enable  = lo_mask;
            mem_write_data   = we_q ? rot_data : 32'h0;
            mem_write_enable = we_q && rst_n;
        end
`ifdef MISALIGNED_SPLIT_EN
        if (state == ACCESS2) begin
            mem_address      = {addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};
            mem_byte_enable  = hi_mask;
            mem_write_data   = we_q ? rot_data : 32'h0;
            mem_write_enable = we_q && rst_n;
        end
`endif
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_fault <= 1'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            fault_q   <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            lo_q      <= 32'h0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        fault_q <= req_fault;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
`ifdef MISALIGNED_SPLIT_EN
                    if (!fault_q && crossing) begin
                        lo_q  <= lane_data;
                        state <= ACCESS2;
                    end else
`endif
                    begin
                        rsp_valid <= 1'b1;
                        rsp_fault <= fault_q;
                        rsp_rdata <= (fault_q || we_q) ? 32'h0 : load_ext(lane_data, f3_q);
                        state     <= RESP;
                    end
                end
`ifdef MISALIGNED_SPLIT_EN
                ACCESS2: begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b0;
                    rsp_rdata <= we_q ? 32'h0 : load_ext(merged, f3_q);
                    state     <= RESP;
                end
`endif
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a word memory model and a response scoreboard.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:63];
    int          n_checks = 0;
    int          n_fail   = 0;

    lsu_mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_byte_enable(mem_byte_enable), .mem_write_enable(mem_write_enable),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, byte-enabled write on the clock edge
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk) begin
        if (mem_write_enable)
            for (int b = 0; b < 4; b++)
                if (mem_byte_enable[b])
                    mem[mem_address[7:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            chk("rsp_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
            end
        end
    end

    // One request from IDLE through the response; called just after a clock edge
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be1, input logic [31:0] wd1, input logic exp_we,
                          input int nacc, input logic [3:0] be2,
                          input logic [31:0] exp_rdata, input logic exp_fault,
                          input logic [31:0] exp_mem);
        exp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.fault = exp_fault;
        e.rdata = exp_rdata;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, ".ready_busy"}, {31'b0, req_ready}, 32'd0);
        chk({tag, ".addr"}, mem_address, {addr[31:2], 2'b00});
        chk({tag, ".be"}, {28'b0, mem_byte_enable}, {28'b0, be1});
        chk({tag, ".wdata"}, mem_write_data, wd1);
        chk({tag, ".we"}, {31'b0, mem_write_enable}, {31'b0, exp_we});
        if (nacc == 2) begin
            @(posedge clk); #1;
            chk({tag, ".addr2"}, mem_address, {addr[31:2], 2'b00} + 32'd4);
            chk({tag, ".be2"}, {28'b0, mem_byte_enable}, {28'b0, be2});
        end
        @(posedge clk); #1;
        chk({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, ".mem"}, mem[addr[7:2]], exp_mem);
        @(posedge clk); #1;
        chk({tag, ".rsp_done"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, ".ready_idle"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset.rsp_rdata", rsp_rdata, 32'h0);
        chk("reset.rsp_fault", {31'b0, rsp_fault}, 32'd0);
        chk("reset.ready", {31'b0, req_ready}, 32'd1);
        chk("reset.we", {31'b0, mem_write_enable}, 32'd0);
        chk("reset.be", {28'b0, mem_byte_enable}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // tag, we, f3, addr, wdata, be1, wd1, we?, nacc, be2, rdata, fault, mem word after
        do_req("sw",  1, 3'b010, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1, 1, 4'h0, 32'h0,        0, 32'hDEADBEEF);
        do_req("lw",  0, 3'b010, 32'h10, 32'h0,        4'b1111, 32'h0,        0, 1, 4'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        do_req("sb",  1, 3'b000, 32'h13, 32'h00000080, 4'b1000, 32'h80808080, 1, 1, 4'h0, 32'h0,        0, 32'h80ADBEEF);
        do_req("lb",  0, 3'b000, 32'h13, 32'h0,        4'b1000, 32'h0,        0, 1, 4'h0, 32'hFFFFFF80, 0, 32'h80ADBEEF);
        do_req("lbu", 0, 3'b100, 32'h13, 32'h0,        4'b1000, 32'h0,        0, 1, 4'h0, 32'h00000080, 0, 32'h80ADBEEF);
        do_req("sh",  1, 3'b001, 32'h12, 32'h00008234, 4'b1100, 32'h82348234, 1, 1, 4'h0, 32'h0,        0, 32'h8234BEEF);
        do_req("lh",  0, 3'b001, 32'h12, 32'h0,        4'b1100, 32'h0,        0, 1, 4'h0, 32'hFFFF8234, 0, 32'h8234BEEF);
        do_req("lhu", 0, 3'b101, 32'h12, 32'h0,        4'b1100, 32'h0,        0, 1, 4'h0, 32'h00008234, 0, 32'h8234BEEF);
        do_req("sw_a", 1, 3'b010, 32'h10, 32'h44332211, 4'b1111, 32'h44332211, 1, 1, 4'h0, 32'h0,      0, 32'h44332211);
        do_req("sw_b", 1, 3'b010, 32'h14, 32'h88776655, 4'b1111, 32'h88776655, 1, 1, 4'h0, 32'h0,      0, 32'h88776655);
`ifdef MISALIGNED_SPLIT_EN
        do_req("lw_mis", 0, 3'b010, 32'h11, 32'h0, 4'b1110, 32'h0, 0, 2, 4'b0001, 32'h55443322, 0, 32'h44332211);
`else
        do_req("lw_mis", 0, 3'b010, 32'h11, 32'h0, 4'b0000, 32'h0, 0, 1, 4'h0,    32'h0,        1, 32'h44332211);
`endif
        do_req("ld_ill", 0, 3'b011, 32'h10, 32'h0,        4'b0000, 32'h0, 0, 1, 4'h0, 32'h0, 1, 32'h44332211);
        do_req("st_ill", 1, 3'b100, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 0, 1, 4'h0, 32'h0, 1, 32'h44332211);

        // Reset during the ACCESS cycle of a store: no write, no response
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h18;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_mid.we_before", {31'b0, mem_write_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.we_gated", {31'b0, mem_write_enable}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid.mem", mem[6], 32'h0);
        chk("rst_mid.ready", {31'b0, req_ready}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_mid.no_rsp", {31'b0, rsp_valid}, 32'd0);
        end

        // Request held while busy: a second request is taken only back in IDLE
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h14;
        e.fault = 1'b0; e.rdata = 32'h88776655; sb.push_back(e);
        @(posedge clk); #1;
        req_funct3 = 3'b100;
        req_addr   = 32'h10;
        e.fault = 1'b0; e.rdata = 32'h00000011; sb.push_back(e);
        chk("hold.ready_access", {31'b0, req_ready}, 32'd0);
        chk("hold.addr_first", mem_address, 32'h14);
        @(posedge clk); #1;
        chk("hold.ready_resp", {31'b0, req_ready}, 32'd0);
        chk("hold.rsp1", {31'b0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        chk("hold.ready_idle", {31'b0, req_ready}, 32'd1);
        chk("hold.no_rsp", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("hold.addr_second", mem_address, 32'h10);
        chk("hold.be_second", {28'b0, mem_byte_enable}, 32'h1);
        @(posedge clk); #1;
        chk("hold.rsp2", {31'b0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        chk("hold.ready_end", {31'b0, req_ready}, 32'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit between the RV32I execute stage and the word-organised data memory. Accepts one load or store request at a time and converts funct3/address/data into memory signals: word address, byte enables, lane-aligned write data and write enable. For loads it extracts and sign- or zero-extends the addressed lane of the memory's combinational read word. It returns a one-cycle response pulse, or a fault for misaligned or illegal accesses.

Parameters:
ADDR_W, 32, width of request and memory address.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  unit idle, can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data (0 for stores/faults)
rsp_fault  out  1  access faulted, valid with rsp_valid
mem_address  out  ADDR_W  word-aligned address, low 2 bits always 0
mem_write_data  out  32  lane-replicated store data
mem_byte_enable  out  4  byte lane mask
mem_write_enable  out  1  write strobe, memory commits on clk edge
mem_read_data  in  32  combinational read word at mem_address

Behaviour:
- Reset (synchronous, rst_n low at posedge): state IDLE; rsp_valid=0, rsp_rdata=0, rsp_fault=0; latched request cleared. While rst_n is low, mem_write_enable=0 combinationally.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. The ACCESS2 state exists only under the optional feature.
- IDLE: req_ready=1. A request is accepted on a posedge with req_valid=1, then latched and the FSM moves to ACCESS.
- ACCESS: req_ready=0.
  - Drive mem_address = {addr[ADDR_W-1:2],2'b00}.
  - Drive mem_write_enable=1 only for a legal store.
  - Load lane is extracted from mem_read_data and registered into rsp_rdata at the end of ACCESS.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure; the consumer must take it.
- Latency: request accepted at edge N, memory write commits at edge N+1, rsp_valid is high in cycle N+2. Back-to-back throughput is one request per 3 cycles.
- Byte enables and data, with o = addr[1:0]:
  - SB: be = 4'b0001<<o; data = byte replicated x4.
  - SH: be = 4'b0011<<o; data = half replicated x2.
  - SW: be = 4'b1111; data unchanged.
- Loads:
  - LB/LBU: byte at lane o, sign/zero extended.
  - LH/LHU: half at bytes o..o+1, sign/zero extended.
  - LW: full word.
- Faults (rsp_fault=1, rsp_rdata=0, mem_write_enable held 0, same 3-cycle timing):
  - Illegal funct3: load 011/110/111; store anything but 000/001/010.
  - Halfword with o[0]=1.
  - Word with o!=0.
- mem_byte_enable and mem_write_data are 0 outside ACCESS.
- req_valid while busy: ignored. req_ready=0; the requester holds.
- Reset mid-operation: request abandoned, no write issued, no response.

Optional Feature:
MISALIGNED_SPLIT_EN
- Without it: misaligned halfword/word accesses fault as above.
- With it: misaligned accesses are performed instead of faulting.
  - Non-crossing accesses complete in one ACCESS with the shifted mask (e.g. SH at o=1: be=4'b0110).
  - Word-crossing accesses (SH/LH at o=3; SW/LW at o=1..3) use ACCESS then ACCESS2.
  - ACCESS handles the low part at word A with be=4'b1111<<o (truncated to 4 bits).
  - ACCESS2 handles the high part at word A+1, wrapping modulo 2^ADDR_W, with the remaining low lanes.
  - Load bytes from ACCESS are held in a 32-bit register and merged in ACCESS2.
  - Latency is 4 cycles. Illegal funct3 still faults.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> be=1111, write at edge N+1, rsp_valid in cycle N+2, rsp_rdata=0xDEADBEEF, fault=0.
- SB 0x80 @0x13 over 0xDEADBEEF -> be=1000, word=0x80ADBEEF; LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080.
- SH 0x8234 @0x12 -> be=1100, word=0x8234BEEF; LH @0x12 -> 0xFFFF8234; LHU -> 0x00008234.
- LW @0x11 -> macro off: rsp_fault=1, rsp_rdata=0, no write. Macro on, words 0x10=0x44332211 and 0x14=0x88776655 -> rdata=0x55443322 after 4 cycles.
- Load funct3=011 and store funct3=100 -> fault=1, mem_write_enable never asserted.
- rst_n low during ACCESS of an SW -> no memory change, no rsp_valid, req_ready=1 after release. req_valid held while busy -> accepted only on return to IDLE.
